// File: rtl/synthesijer_div_arb_pkg.sv
// Shared definitions for the divider arbiter: FSM state encoding and the default watchdog limit.
package synthesijer_div_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/synthesijer_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above rr_ptr, wrapping.
// Kept generic so other shared-unit arbiters (mul, fdiv) can reuse it.
module synthesijer_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] rr_ptr,
    output logic            any,
    output logic [IDXW-1:0] idx
);

    assign any = |req;

    always_comb begin
        logic found;
        int   c;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int i = 0; i < NREQ; i++) begin
            c = int'(rr_ptr) + i;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = IDXW'(c);
            end
        end
    end

endmodule

// File: rtl/synthesijer_div_arbiter.sv
// Shares one variable-latency signed divider among NREQ requesters with round-robin
// arbitration, one division in flight, and a watchdog that aborts and resets a hung divider.
module synthesijer_div_arbiter
    import synthesijer_div_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDXW    = 2,
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic                    err,
    output logic [WIDTH-1:0]        quantient,
    output logic [WIDTH-1:0]        remainder,
    output logic [WIDTH-1:0]        div_a,
    output logic [WIDTH-1:0]        div_b,
    output logic                    div_nd,
    output logic                    div_reset,
    input  logic [WIDTH-1:0]        div_quantient,
    input  logic [WIDTH-1:0]        div_remainder,
    input  logic                    div_valid
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state, next_state;
    logic [IDXW-1:0] idx, rr_ptr, pick_idx;
    logic            pick_any;
    logic [CW-1:0]   cnt;
    logic            timeout_hit;

    synthesijer_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    assign timeout_hit = (cnt == CW'(TIMEOUT));

    // The divider is reset both by the system reset and by a watchdog abort in RESP.
    assign div_reset = reset | ((state == S_RESP) && err);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (pick_any) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (div_valid || timeout_hit) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Pulses are registered on the transition into the state they belong to,
    // so grant/div_nd are high during ISSUE and done during RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            grant     <= '0;
            done      <= '0;
            err       <= 1'b0;
            quantient <= '0;
            remainder <= '0;
            div_a     <= '0;
            div_b     <= '0;
            div_nd    <= 1'b0;
        end else begin
            grant  <= '0;
            done   <= '0;
            div_nd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        idx    <= pick_idx;
                        div_a  <= a_in[int'(pick_idx)*WIDTH +: WIDTH];
                        div_b  <= b_in[int'(pick_idx)*WIDTH +: WIDTH];
                        grant  <= NREQ'(1) << pick_idx;
                        div_nd <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    cnt <= '0;
                end
                S_WAIT: begin
                    if (div_valid) begin
                        quantient <= div_quantient;
                        remainder <= div_remainder;
                        err       <= 1'b0;
                        done      <= NREQ'(1) << idx;
                    end else if (timeout_hit) begin
                        quantient <= '0;
                        remainder <= '0;
                        err       <= 1'b1;
                        done      <= NREQ'(1) << idx;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    rr_ptr <= (idx == IDXW'(NREQ - 1)) ? '0 : idx + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_synthesijer_div_arbiter.sv
// Directed bench for synthesijer_div_arbiter with a behavioural fixed-latency divider
// that can be made to hang or to emit a spurious valid.
module tb_synthesijer_div_arbiter;

    localparam int NREQ    = 4;
    localparam int IDXW    = 2;
    localparam int WIDTH   = 64;
    localparam int TIMEOUT = 20;
    localparam int LAT     = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in, b_in;
    logic [NREQ-1:0]       grant, done;
    logic                  err;
    logic [WIDTH-1:0]      quantient, remainder, div_a, div_b;
    logic                  div_nd, div_reset;
    logic [WIDTH-1:0]      div_quantient, div_remainder;
    logic                  div_valid;

    logic                  hang, inject_stale;
    logic                  m_busy;
    int                    m_cnt;
    logic signed [63:0]    m_a, m_b;

    int nApplied = 0;
    int nMiscompare = 0;
    int strayGrant = 0;

    always #5 clk = ~clk;

    synthesijer_div_arbiter #(
        .NREQ(NREQ), .IDXW(IDXW), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
        .grant(grant), .done(done), .err(err),
        .quantient(quantient), .remainder(remainder),
        .div_a(div_a), .div_b(div_b), .div_nd(div_nd), .div_reset(div_reset),
        .div_quantient(div_quantient), .div_remainder(div_remainder), .div_valid(div_valid)
    );

    // Divider model: result LAT cycles after nd; b == 0 yields q = -1, r = a.
    always @(posedge clk) begin
        if (div_reset) begin
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            div_valid <= 1'b0;
        end else begin
            div_valid <= 1'b0;
            if (inject_stale) begin
                div_valid     <= 1'b1;
                div_quantient <= 64'd999;
                div_remainder <= 64'd999;
            end
            if (div_nd) begin
                m_busy <= 1'b1;
                m_cnt  <= LAT;
                m_a    <= div_a;
                m_b    <= div_b;
            end else if (m_busy && !hang) begin
                if (m_cnt == 1) begin
                    m_busy    <= 1'b0;
                    div_valid <= 1'b1;
                    if (m_b == 0) begin
                        div_quantient <= '1;
                        div_remainder <= m_a;
                    end else begin
                        div_quantient <= m_a / m_b;
                        div_remainder <= m_a % m_b;
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    typedef struct {
        int                 idx;
        logic signed [63:0] a;
        logic signed [63:0] b;
        logic signed [63:0] q;
        logic signed [63:0] r;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic boundExpired(input string name);
        nApplied++;
        nMiscompare++;
        $display("[TB] FAIL %s: wait bound expired, got no event, expected one", name);
    endtask

    task automatic applyStimulus(input int idx, input logic signed [63:0] a, input logic signed [63:0] b);
        a_in[idx*WIDTH +: WIDTH] = a;
        b_in[idx*WIDTH +: WIDTH] = b;
        req[idx] = 1'b1;
    endtask

    task automatic waitDone(input int bound, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
            if (grant != 0) strayGrant++;
        end while (done == 0 && cycles < bound);
        if (done == 0) boundExpired("done_wait");
    endtask

    // Lone request from IDLE: strict one-cycle grant and LAT+2 cycles grant-to-done.
    task automatic runOp(input string tag, input int idx, input logic signed [63:0] a,
                         input logic signed [63:0] b, input logic signed [63:0] q,
                         input logic signed [63:0] r);
        int cyc;
        applyStimulus(idx, a, b);
        step();
        checkOutput({tag, "_grant"}, 64'(grant), 64'(1) << idx);
        checkOutput({tag, "_div_nd"}, 64'(div_nd), 64'd1);
        req[idx] = 1'b0;
        waitDone(40, cyc);
        checkOutput({tag, "_latency"}, 64'(cyc), 64'(LAT + 2));
        checkOutput({tag, "_done"}, 64'(done), 64'(1) << idx);
        checkOutput({tag, "_q"}, quantient, q);
        checkOutput({tag, "_r"}, remainder, r);
        checkOutput({tag, "_err"}, 64'(err), 64'd0);
        step();
    endtask

    // Under contention: wait for the next grant, expect it to be idx, then its done.
    task automatic expectServed(input string tag, input int idx,
                                input logic signed [63:0] q, input logic signed [63:0] r);
        int cyc = 0;
        do begin
            step();
            cyc++;
        end while (grant == 0 && cyc < 20);
        if (grant == 0) boundExpired({tag, "_grant_wait"});
        checkOutput({tag, "_grant"}, 64'(grant), 64'(1) << idx);
        req[idx] = 1'b0;
        waitDone(40, cyc);
        checkOutput({tag, "_done"}, 64'(done), 64'(1) << idx);
        checkOutput({tag, "_q"}, quantient, q);
        checkOutput({tag, "_r"}, remainder, r);
    endtask

    initial begin
        int cyc;
        logic sawDone;

        vecs[0] = '{0, 100, 7, 14, 2};
        vecs[1] = '{2, -100, 7, -14, -2};
        vecs[2] = '{1, 100, -7, -14, 2};
        vecs[3] = '{3, -100, -7, 14, -2};
        vecs[4] = '{1, 7, 100, 0, 7};
        vecs[5] = '{0, 0, 5, 0, 0};
        vecs[6] = '{3, 42, 0, -1, 42};

        reset = 1'b1;
        req = '0;
        a_in = '0;
        b_in = '0;
        hang = 1'b0;
        inject_stale = 1'b0;
        step();
        step();
        checkOutput("rst_grant", 64'(grant), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_q", quantient, 64'd0);
        checkOutput("rst_div_nd", 64'(div_nd), 64'd0);
        checkOutput("rst_div_reset", 64'(div_reset), 64'd1);
        reset = 1'b0;
        step();
        checkOutput("idle_div_reset", 64'(div_reset), 64'd0);

        for (int i = 0; i < 7; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
        end

        // Contention from reset release; requester 0 re-requests after its first done.
        reset = 1'b1;
        applyStimulus(0, 100, 7);
        applyStimulus(1, 200, 7);
        applyStimulus(3, 400, 7);
        step();
        reset = 1'b0;
        expectServed("cont0", 0, 14, 2);
        req[0] = 1'b1;
        expectServed("cont1", 1, 28, 4);
        expectServed("cont3", 3, 57, 1);
        expectServed("cont0b", 0, 14, 2);
        step();

        // rr_ptr is 1; serving 2 moves it to 3, then 3 must beat 0.
        runOp("wrap_pre", 2, 50, 7, 7, 1);
        applyStimulus(3, 9, 2);
        applyStimulus(0, -9, 2);
        expectServed("wrap3", 3, 4, 1);
        expectServed("wrap0", 0, -4, -1);
        step();

        hang = 1'b1;
        applyStimulus(1, 10, 3);
        step();
        checkOutput("to_grant", 64'(grant), 64'd2);
        req[1] = 1'b0;
        waitDone(100, cyc);
        checkOutput("to_latency", 64'(cyc), 64'(TIMEOUT + 2));
        checkOutput("to_done", 64'(done), 64'd2);
        checkOutput("to_err", 64'(err), 64'd1);
        checkOutput("to_q", quantient, 64'd0);
        checkOutput("to_r", remainder, 64'd0);
        checkOutput("to_div_reset", 64'(div_reset), 64'd1);
        step();
        checkOutput("to_div_reset_clr", 64'(div_reset), 64'd0);
        hang = 1'b0;
        runOp("after_to", 1, 10, 3, 3, 1);

        applyStimulus(0, 1000, 10);
        step();
        req[0] = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        checkOutput("mid_rst_grant", 64'(grant), 64'd0);
        checkOutput("mid_rst_done", 64'(done), 64'd0);
        checkOutput("mid_rst_q", quantient, 64'd0);
        checkOutput("mid_rst_r", remainder, 64'd0);
        checkOutput("mid_rst_div_a", div_a, 64'd0);
        checkOutput("mid_rst_div_b", div_b, 64'd0);
        checkOutput("mid_rst_div_reset", 64'(div_reset), 64'd1);
        reset = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 8; i++) begin
            inject_stale = (i == 2);
            step();
            if (done != 0) sawDone = 1'b1;
        end
        inject_stale = 1'b0;
        checkOutput("mid_rst_no_done", 64'(sawDone), 64'd0);
        checkOutput("stale_ignored_q", quantient, 64'd0);
        runOp("after_rst", 2, 1000, 10, 100, 0);

        checkOutput("stray_grant", 64'(strayGrant), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

endmodule
